sig_watch: RTL and testbench
============================

# sig_watch

Passive bus observer for the tiny Thumb core's memory bus. It sits alongside the memory model, snoops every completed transfer, and captures byte-merged writes to the signature word. It also watches an optional fail word and runs a cycle-budget watchdog. It produces a registered PASS/FAIL/TIMEOUT verdict, so benches and the FPGA top can self-check without peeking into memory arrays.

## Interface
Parameters:
- SIG_ADDR, 32'h0000_0100, byte address of signature word (word-aligned; bits [1:0] ignored)
- FAIL_ADDR, 32'h0000_0104, any completed write here forces FAIL
- EXPECTED_SIG, 32'h0000_00A1, pass value
- TIMEOUT_CYCLES, 800, RUN cycles before the watchdog verdict
- CNT_W, 16, cycle counter width; must satisfy TIMEOUT_CYCLES < 2**CNT_W

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  core request valid
- mem_we  in  1  write enable
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes, bit n covers wdata[8n+7:8n]
- mem_ready  in  1  memory completion
- done  out  1  verdict reached (sticky)
- pass  out  1  signature matched (sticky)
- fail  out  1  mismatch-at-timeout, fail-word write, or protocol error (sticky)
- timeout  out  1  watchdog expired with no signature write ever seen
- sig_value  out  32  current merged signature register
- cycle_count  out  CNT_W  RUN cycles elapsed
- proto_err  out  1  bus protocol violation seen (sticky)

## Operation
- Handshake: a transfer completes in a cycle with mem_valid & mem_ready. Only completed writes (mem_we=1) are considered; reads are ignored.
- Address match compares mem_addr[31:2] against SIG_ADDR[31:2] or FAIL_ADDR[31:2].
- Signature write: each byte n with mem_wstrb[n]=1 replaces sig_value byte n. Sets internal sig_seen. The merged next value is compared with EXPECTED_SIG.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal until reset.
- IDLE -> RUN on the first clock edge with rst_n high.
- RUN -> PASS when a signature write's merged value equals EXPECTED_SIG. Writes with wstrb=0 are still evaluated.
- A mismatching signature write stays in RUN, so intermediate values are allowed.
- RUN -> FAIL on a completed write to FAIL_ADDR.
- RUN -> FAIL at cycle_count == TIMEOUT_CYCLES-1 when sig_seen=1.
- RUN -> TIMEOUT at cycle_count == TIMEOUT_CYCLES-1 when sig_seen=0.
- Priority within one cycle: PASS > FAIL_ADDR write > protocol error > watchdog.
- cycle_count increments every cycle in RUN and freezes in terminal states.
- sig_value continues to merge signature writes in every state, for debug.
- Outputs: done = (state is PASS, FAIL or TIMEOUT); pass, fail and timeout decode state.

## Timing
- Reset values: state IDLE; sig_value 0; cycle_count 0; sig_seen 0; done, pass, fail, timeout and proto_err all 0.
- Reset is asynchronous. Assertion mid-run clears everything immediately, including terminal verdicts.
- Verdict latency: the handshake cycle is sampled at edge N, and the verdict outputs are high after edge N.
- sig_value reflects a write one edge after its handshake.
- Watchdog: first RUN cycle has cycle_count=0. The verdict becomes visible after exactly TIMEOUT_CYCLES RUN edges.
- Zero combinational paths from inputs to outputs. The block never drives the bus.

## Configuration
- SIG_WATCH_PROTO_CHK_EN defined: a pending request (mem_valid=1, mem_ready=0) must keep mem_valid high with mem_we, mem_addr, mem_wdata and mem_wstrb unchanged on the next cycle.
  - A violation sets proto_err one edge later.
  - If the state is RUN, a violation also moves it to FAIL.
  - Checking is active in all non-IDLE states; proto_err is sticky.
- Not defined: proto_err is constant 0, no pending-request registers exist, and the protocol-error transition is absent.

## Test plan
- Write 32'h000000A1, wstrb=4'hF, to 0x100 at RUN cycle 20 -> pass=1 and done=1 after that edge, sig_value=0x000000A1, cycle_count frozen at 21.
- Write 0x11 then 0x22 to 0x100, no further writes, TIMEOUT_CYCLES=50 -> fail=1 after edge 50, sig_value=0x22, timeout=0.
- No bus activity, TIMEOUT_CYCLES=50 -> timeout=1, fail=0 and cycle_count=49 after 50 RUN edges.
- Write 0xAABBCCDD with wstrb 4'h3, then 0x000000A1 with wstrb 4'h1; EXPECTED_SIG=32'h0000CCA1 -> first write gives sig_value=0x0000CCDD, still RUN; second gives 0x0000CCA1 and pass.
- A write to 0x104 in the same cycle the watchdog expires -> FAIL. A matching signature write in the same cycle as the expiry -> PASS.
- With SIG_WATCH_PROTO_CHK_EN: hold mem_valid=1 and mem_ready=0, change mem_addr next cycle -> proto_err=1 and fail=1 one edge later. Pulse rst_n low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/sig_watch.sv
// Passive memory-bus observer: merges signature-word writes, watches a fail word and a
// cycle-budget watchdog, and latches a PASS/FAIL/TIMEOUT verdict. Optional bus protocol
// checking is compiled in with `define SIG_WATCH_PROTO_CHK_EN.
module sig_watch #(
   parameter logic [31:0] SIG_ADDR       = 32'h0000_0100,
   parameter logic [31:0] FAIL_ADDR      = 32'h0000_0104,
   parameter logic [31:0] EXPECTED_SIG   = 32'h0000_00A1,
   parameter int          TIMEOUT_CYCLES = 800,
   parameter int          CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_valid,
   input  logic             mem_we,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   input  logic [3:0]       mem_wstrb,
   input  logic             mem_ready,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [31:0]      sig_value,
   output logic [CNT_W-1:0] cycle_count,
   output logic             proto_err
);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

   state_t           state_q, state_d;
   logic [31:0]      sig_q, sig_d, sig_merge;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             seen_q, seen_d;
   logic             wr_done, sig_hit, fail_hit, sig_match, wdog, viol;

   assign wr_done   = mem_valid & mem_ready & mem_we;
   assign sig_hit   = wr_done & (mem_addr[31:2] == SIG_ADDR[31:2]);
   assign fail_hit  = wr_done & (mem_addr[31:2] == FAIL_ADDR[31:2]);
   assign sig_match = sig_hit & (sig_merge == EXPECTED_SIG);
   assign wdog      = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      sig_merge = sig_q;
      for (int n = 0; n < 4; n++)
         if (mem_wstrb[n]) sig_merge[8*n +: 8] = mem_wdata[8*n +: 8];
   end

   // Signature merging runs in every state so the final value stays visible for debug.
   assign sig_d  = sig_hit ? sig_merge : sig_q;
   assign seen_d = seen_q | sig_hit;
   // The counter stops on the expiry cycle so it reads TIMEOUT_CYCLES-1 in the verdict.
   assign cnt_d  = (state_q == S_RUN && !wdog) ? cnt_q + 1'b1 : cnt_q;

`ifdef SIG_WATCH_PROTO_CHK_EN
   logic        pend_q, we_q, perr_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  wstrb_q;

   assign viol = pend_q && (state_q != S_IDLE) &&
                 (!mem_valid || mem_we != we_q || mem_addr != addr_q ||
                  mem_wdata != wdata_q || mem_wstrb != wstrb_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         perr_q  <= 1'b0;
      end else begin
         pend_q  <= mem_valid & ~mem_ready;
         we_q    <= mem_we;
         addr_q  <= mem_addr;
         wdata_q <= mem_wdata;
         wstrb_q <= mem_wstrb;
         if (viol) perr_q <= 1'b1;
      end
   end

   assign proto_err = perr_q;
`else
   assign viol      = 1'b0;
   assign proto_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sig_q   <= '0;
         cnt_q   <= '0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         seen_q  <= seen_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: state_d = S_RUN;
         S_RUN: begin
            if (sig_match)     state_d = S_PASS;
            else if (fail_hit) state_d = S_FAIL;
            else if (viol)     state_d = S_FAIL;
            else if (wdog)     state_d = seen_d ? S_FAIL : S_TIMEOUT;
         end
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      pass    = 1'b0;
      fail    = 1'b0;
      timeout = 1'b0;
      case (state_q)
         S_PASS:    pass    = 1'b1;
         S_FAIL:    fail    = 1'b1;
         S_TIMEOUT: timeout = 1'b1;
         default: ;
      endcase
      done = pass | fail | timeout;
   end

   assign sig_value   = sig_q;
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_sig_watch.sv
// Self-checking bench for sig_watch: scoreboarded signature merging, verdict scenarios,
// watchdog boundary, async reset and (when compiled in) protocol checking.
module tb_sig_watch;
   localparam logic [31:0] EXP = 32'h0000_CCA1;
   localparam int          TO  = 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_valid = 1'b0, mem_we = 1'b0, mem_ready = 1'b0;
   logic [31:0] mem_addr = '0, mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        done, pass, fail, timeout, proto_err;
   logic [31:0] sig_value;
   logic [15:0] cycle_count;

   int checks = 0, failures = 0, cyc = 0;
   logic [31:0] msig;
   logic [31:0] sbq[$];

   sig_watch #(.SIG_ADDR(32'h100), .FAIL_ADDR(32'h104), .EXPECTED_SIG(EXP),
               .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .done(done), .pass(pass), .fail(fail),
      .timeout(timeout), .sig_value(sig_value), .cycle_count(cycle_count),
      .proto_err(proto_err));

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic bus_idle();
      mem_valid = 1'b0; mem_ready = 1'b0; mem_we = 1'b0;
      mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
   endtask

   // Asserts reset between edges, checks the asynchronous clear, then enters RUN cycle 0.
   task automatic do_reset();
      @(negedge clk);
      #3 rst_n = 1'b0;
      bus_idle();
      #1;
      checks++;
      if ({done, pass, fail, timeout, proto_err} !== 5'b0 || sig_value !== 32'h0 ||
          cycle_count !== 16'h0) begin
         failures++;
         $display("FAIL async_reset got flags=%b sig=%h cnt=%0d want all zero",
                  {done, pass, fail, timeout, proto_err}, sig_value, cycle_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cyc = 0;
      msig = '0;
   endtask

   task automatic run_to(input int k);
      while (cyc < k) step();
   endtask

   task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic we);
      mem_valid = 1'b1; mem_ready = 1'b1; mem_we = we;
      mem_addr = a; mem_wdata = d; mem_wstrb = s;
      if (we && a[31:2] == 30'h40)
         for (int n = 0; n < 4; n++) if (s[n]) msig[8*n +: 8] = d[8*n +: 8];
      sbq.push_back(msig);
      step();
      bus_idle();
      checks++;
      if (sbq.size() == 0) begin
         failures++;
         $display("FAIL sb_underflow queue empty");
      end else begin
         logic [31:0] e;
         e = sbq.pop_front();
         if (sig_value !== e) begin
            failures++;
            $display("FAIL sig_value got %h want %h", sig_value, e);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic test_reset();
      do_reset();
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_cnt0", {16'b0, cycle_count}, 32'h0);
      step();
      chk("rst_cnt1", {16'b0, cycle_count}, 32'h1);
   endtask

   task automatic test_pass();
      do_reset();
      run_to(20);
      xfer(32'h100, EXP, 4'hF, 1'b1);
      chk("pass_pass", {31'b0, pass}, 32'h1);
      chk("pass_done", {31'b0, done}, 32'h1);
      chk("pass_cnt", {16'b0, cycle_count}, 32'd21);
      repeat (5) step();
      chk("pass_frozen", {16'b0, cycle_count}, 32'd21);
      chk("pass_sticky", {31'b0, pass}, 32'h1);
   endtask

   task automatic test_midrun_reset();
      // Verdict from the previous test is still latched; reset must clear it at once.
      chk("pre_rst_done", {31'b0, done}, 32'h1);
      do_reset();
   endtask

   task automatic test_sig_fail();
      do_reset();
      run_to(3);
      xfer(32'h100, 32'h11, 4'hF, 1'b1);
      xfer(32'h100, 32'h22, 4'hF, 1'b1);
      run_to(TO - 1);
      chk("sf_before", {31'b0, done}, 32'h0);
      step();
      chk("sf_fail", {31'b0, fail}, 32'h1);
      chk("sf_tmo", {31'b0, timeout}, 32'h0);
      chk("sf_sig", sig_value, 32'h22);
   endtask

   task automatic test_timeout();
      do_reset();
      run_to(TO - 1);
      chk("to_before", {31'b0, timeout}, 32'h0);
      chk("to_cnt_pre", {16'b0, cycle_count}, TO - 1);
      step();
      chk("to_tmo", {31'b0, timeout}, 32'h1);
      chk("to_fail", {31'b0, fail}, 32'h0);
      chk("to_cnt", {16'b0, cycle_count}, TO - 1);
   endtask

   task automatic test_merge();
      do_reset();
      run_to(2);
      xfer(32'h100, 32'hAABB_CCDD, 4'h3, 1'b1);
      chk("mg_run", {31'b0, done}, 32'h0);
      xfer(32'h100, 32'h1234_5678, 4'hF, 1'b0);   // read: ignored
      xfer(32'h200, 32'hDEAD_BEEF, 4'hF, 1'b1);   // other address: ignored
      xfer(32'h101, 32'h0000_00A1, 4'h1, 1'b1);   // low address bits ignored
      chk("mg_pass", {31'b0, pass}, 32'h1);
      xfer(32'h100, 32'hFFFF_FFFF, 4'h8, 1'b1);   // still merges after the verdict
      chk("mg_sticky", {31'b0, pass}, 32'h1);
   endtask

   task automatic test_same_cycle();
      do_reset();
      run_to(TO - 1);
      xfer(32'h104, 32'h0, 4'hF, 1'b1);
      chk("sc_failaddr", {30'b0, fail, timeout}, 32'h2);
      do_reset();
      run_to(TO - 1);
      xfer(32'h100, EXP, 4'hF, 1'b1);
      chk("sc_pass", {30'b0, pass, fail}, 32'h2);
   endtask

   task automatic test_proto();
      do_reset();
      run_to(2);
      // Legal: held pending request that then completes.
      mem_valid = 1'b1; mem_ready = 1'b0; mem_we = 1'b1; mem_addr = 32'h200;
      mem_wdata = 32'h5; mem_wstrb = 4'hF;
      step();
      mem_ready = 1'b1;
      step();
      bus_idle();
      step();
      chk("pc_legal", {31'b0, proto_err}, 32'h0);
      // Illegal: address changes while pending.
      mem_valid = 1'b1; mem_ready = 1'b0; mem_we = 1'b1; mem_addr = 32'h200;
      step();
      mem_addr = 32'h204;
      step();
      bus_idle();
`ifdef SIG_WATCH_PROTO_CHK_EN
      chk("pc_err", {31'b0, proto_err}, 32'h1);
      chk("pc_fail", {31'b0, fail}, 32'h1);
`else
      chk("pc_err_off", {31'b0, proto_err}, 32'h0);
      chk("pc_fail_off", {31'b0, fail}, 32'h0);
`endif
      step();
      test_midrun_reset_any();
   endtask

   task automatic test_midrun_reset_any();
      do_reset();
      chk("pc_rst_err", {31'b0, proto_err}, 32'h0);
   endtask

   initial begin
      test_reset();
      test_pass();
      test_midrun_reset();
      test_sig_fail();
      test_timeout();
      test_merge();
      test_same_cycle();
      test_proto();
      chk("sb_empty", sbq.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
